mac_csr_arbiter: RTL

Shares the single Avalon-MM configuration port of the Ethernet MAC among several register-access clients: the power-up configuration sequencer, the runtime statistics poller and the UDP-side host command path. It sits between those clients and the MAC control interface. It arbitrates with an init-lock and round-robin policy, runs exactly one Avalon transaction at a time, returns read data and completion or timeout pulses per client, and aborts transactions whose waitrequest never clears.

---
 rtl/mac_csr_arbiter_pkg.sv | 40 ++++
 rtl/mac_csr_arbiter_rr_pick.sv | 32 +++
 rtl/mac_csr_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mac_csr_arbiter_pkg.sv
// Shared definitions for the MAC CSR arbiter:
// CSR map, command-register bits and FSM encodings.
package mac_csr_arbiter_pkg;

    // MAC CSR word addresses
    localparam logic [7:0] CSR_SCRATCH     = 8'h01;
    localparam logic [7:0] CSR_COMMAND     = 8'h02;
    localparam logic [7:0] CSR_MAC_0       = 8'h03;
    localparam logic [7:0] CSR_MAC_1       = 8'h04;
    localparam logic [7:0] CSR_FRM_LENGTH  = 8'h05;
    localparam logic [7:0] CSR_PAUSE_QUANT = 8'h06;
    localparam logic [7:0] CSR_TX_IPG      = 8'h17;

    // command_config bit positions
    localparam int CMD_TX_ENA       = 0;
    localparam int CMD_RX_ENA       = 1;
    localparam int CMD_XON_GEN      = 2;
    localparam int CMD_ETH_SPEED    = 3;
    localparam int CMD_PROMIS_EN    = 4;
    localparam int CMD_PAD_EN       = 5;
    localparam int CMD_CRC_FWD      = 6;
    localparam int CMD_PAUSE_IGNORE = 8;
    localparam int CMD_TX_ADDR_INS  = 9;
    localparam int CMD_HD_ENA       = 10;
    localparam int CMD_SW_RESET     = 13;
    localparam int CMD_LOOP_ENA     = 15;

    // Arbiter FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Build a command word with a single bit set
    function automatic logic [31:0] cmd_bit(input int b);
        return 32'(1) << b;
    endfunction

endpackage

// File: rtl/mac_csr_arbiter_rr_pick.sv
// Round-robin priority picker: scans the eligible
// vector upward from last+1 with wrap-around.
module mac_csr_arbiter_rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // First eligible port after the last winner wins
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(last) + 1 + i) % NREQ);
            if (!any && elig[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mac_csr_arbiter.sv
// Shares the MAC Avalon-MM CSR port among NREQ clients
// with an init lock, round-robin and a stuck-slave timeout.
module mac_csr_arbiter
    import mac_csr_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_done,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*8-1:0]  req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    err,
    output logic [31:0]        rdata,
    output logic               busy,
    output logic [7:0]         address,
    output logic               write,
    output logic               read,
    output logic [31:0]        writedata,
    input  logic [31:0]        readdata,
    input  logic               waitrequest
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] PORT0 = NREQ'(1);
    localparam logic [NREQ-1:0] ALL   = '1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam logic [IW-1:0]   LAST0  = IW'(NREQ - 1);

    state_t          state;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   last_grant;
    logic            wr_q;
    logic [TO_W-1:0] cnt;
    logic [NREQ-1:0] blk;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    // Eligible: requesting, not just served, and port 0 only until init ends
    always_comb begin
        elig = req & ~blk & (cfg_done ? ALL : PORT0);
    end

    mac_csr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .elig (elig),
        .last (last_grant),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign busy = (state != ST_IDLE);

    // Arbitration FSM driving the Avalon command and client pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt_q      <= '0;
            gidx       <= '0;
            last_grant <= LAST0;
            wr_q       <= 1'b0;
            cnt        <= '0;
            blk        <= '0;
            ack        <= '0;
            err        <= '0;
            rdata      <= '0;
            address    <= '0;
            write      <= 1'b0;
            read       <= 1'b0;
            writedata  <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            blk <= ack | err;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_q     <= pick_gnt;
                        gidx      <= pick_idx;
                        wr_q      <= req_wr[pick_idx];
                        address   <= req_addr[int'(pick_idx)*8 +: 8];
                        writedata <= req_wdata[int'(pick_idx)*32 +: 32];
                        write     <= req_wr[pick_idx];
                        read      <= ~req_wr[pick_idx];
                        cnt       <= '0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!waitrequest) begin
                        write      <= 1'b0;
                        read       <= 1'b0;
                        ack        <= gnt_q;
                        last_grant <= gidx;
                        state      <= ST_DONE;
                        if (!wr_q) begin
                            rdata <= readdata;
                        end
                    end else if (cnt == TO_LIM) begin
                        write      <= 1'b0;
                        read       <= 1'b0;
                        err        <= gnt_q;
                        last_grant <= gidx;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
